// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only I-cache between PC and imem.
// Ports: clk, rst_n, pc_addr->inst/hit, flush, mem_req/addr/ack/data.
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_fetch #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_addr,
  output logic [15:0] inst,
  output logic        hit,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = 16 - IDX - OFF;
  localparam int LB  = 16 - OFF;

  typedef enum logic {LOOKUP, FILL} state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG-1:0]       tag_q  [NUM_LINES];
  logic [15:0]          data_q [NUM_LINES][LINE_WORDS];

  logic [IDX-1:0] lk_idx;
  logic [TAG-1:0] lk_tag;
  logic [OFF-1:0] lk_off;
  logic [LB-1:0]  fill_q;
  logic [IDX-1:0] f_idx;
  logic [OFF-1:0] beat_q;
  logic [OFF-1:0] beat_nx;
  logic           lk_hit;
  logic           miss;
  logic           take;
  logic           last;

  assign lk_idx  = pc_addr[OFF +: IDX];
  assign lk_tag  = pc_addr[15 -: TAG];
  assign lk_off  = pc_addr[OFF-1:0];
  assign f_idx   = fill_q[IDX-1:0];
  assign beat_nx = beat_q + 1'b1;
  assign last    = &beat_q;

  assign lk_hit = valid_q[lk_idx]
               && (tag_q[lk_idx] == lk_tag)
               && !flush;

  assign miss = (state_q == LOOKUP)
             && !flush && !lk_hit;

  // A flush aborts the fill, so the
  // beat that arrives with it is dropped.
  assign take = (state_q == FILL)
             && mem_ack && !flush;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    inst    = 16'h0000;
    unique case (state_q)
      LOOKUP: begin
        hit = lk_hit;
        if (lk_hit)
          inst = data_q[lk_idx][lk_off];
        if (miss)
          state_d = FILL;
      end
      FILL: begin
        if (flush)
          state_d = LOOKUP;
        else if (take && last)
          state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOOKUP;
      valid_q  <= '0;
      beat_q   <= '0;
      fill_q   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (flush) begin
        valid_q  <= '0;
        beat_q   <= '0;
        mem_req  <= 1'b0;
        mem_addr <= 16'h0000;
      end else if (miss) begin
        // Old contents of the victim line are
        // dead from the first fill beat on.
        valid_q[lk_idx] <= 1'b0;
        fill_q   <= pc_addr[15:OFF];
        beat_q   <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {pc_addr[15:OFF],
                     {OFF{1'b0}}};
      end else if (take) begin
        beat_q <= beat_nx;
        if (last) begin
          valid_q[f_idx] <= 1'b1;
          mem_req  <= 1'b0;
          mem_addr <= 16'h0000;
        end else begin
          mem_addr <= {fill_q, beat_nx};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      data_q[f_idx][beat_q] <= mem_data;
      if (last)
        tag_q[f_idx] <= fill_q[LB-1 -: TAG];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (flush) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (hit && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (miss && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: scoreboard bench for icache_fetch.
// Memory model answers fills with 0xA000+addr.
module tb_icache_fetch;

  localparam int LW = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_addr;
  logic [15:0] inst;
  logic        hit;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  icache_fetch #(
    .NUM_LINES (16),
    .LINE_WORDS(LW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc_addr (pc_addr),
    .inst    (inst),
    .hit     (hit),
    .flush   (flush),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] iq [$];
  logic [15:0] aq [$];
  int beats = 0;
  int cnt   = 0;
  int gap   = 0;
  bit hold  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Memory: acks once every gap+1 cycles of
  // an active request; checks each beat addr.
  always @(negedge clk) begin
    if (mem_req && !hold) begin
      if (beats < aq.size())
        chk("maddr", {16'h0, mem_addr},
            {16'h0, aq[beats]});
      else
        chk("unexp_req", {31'h0, mem_req}, 0);
      if (cnt == gap) begin
        mem_ack  = 1'b1;
        mem_data = 16'hA000 + mem_addr;
        beats++;
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      if (!mem_req) cnt = 0;
    end
  end

  task automatic push_fill(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    for (int i = 0; i < LW; i++)
      aq.push_back(b + 16'(i));
  endtask

  task automatic trim_aq();
    while (aq.size() > beats)
      void'(aq.pop_back());
  endtask

  // Called just after a rising edge.
  task automatic fetch(input logic [15:0] a,
                       input bit miss);
    int n;
    n = 0;
    pc_addr = a;
    iq.push_back(16'hA000 + a);
    if (miss) push_fill(a);
    @(negedge clk);
    chk("hit_first", {31'h0, hit},
        {31'h0, !miss});
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hit_seen", {31'h0, hit}, 1);
    if (miss) begin
      chk("miss_lat", n, 1 + LW * (gap + 1));
      chk("beats_done", beats, aq.size());
    end
    chk("inst", {16'h0, inst},
        {16'h0, iq.pop_front()});
    chk("req_idle", {31'h0, mem_req}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_wait", {31'h0, beats >= target}, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    pc_addr = 16'h0000;
    mem_ack = 1'b0;
    mem_data = 16'h0000;
    #12;
    chk("rst_hit", {31'h0, hit}, 0);
    chk("rst_inst", {16'h0, inst}, 0);
    chk("rst_req", {31'h0, mem_req}, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cold miss then same-line hits
    fetch(16'h0012, 1'b1);
    for (int i = 0; i < LW; i++)
      fetch(16'h0010 + 16'(i), 1'b0);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", {16'h0, hit_count}, 5);
    chk("miss_cnt", {16'h0, miss_count}, 1);
`endif

    // conflict eviction on index 4
    fetch(16'h0052, 1'b1);
    fetch(16'h0053, 1'b0);
    fetch(16'h0012, 1'b1);

    // stalled memory: ack every third cycle
    gap = 2;
    fetch(16'h0031, 1'b1);
    fetch(16'h0030, 1'b0);
    gap = 0;

    // flush in lookup drops everything
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(16'h0031, 1'b1);

    // flush at beat 2 aborts the fill
    pc_addr = 16'h0100;
    push_fill(16'h0100);
    wait_beats(beats + 2 - (beats % 1));
    flush = 1'b1;
    hold  = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_req", {31'h0, mem_req}, 0);
    chk("flush_hit", {31'h0, hit}, 0);
    hold = 1'b0;
    trim_aq();
    fetch(16'h0100, 1'b1);

    // async reset at beat 1
    pc_addr = 16'h0200;
    push_fill(16'h0200);
    wait_beats(beats + 1);
    hold  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, mem_req}, 0);
    chk("arst_addr", {16'h0, mem_addr}, 0);
    chk("arst_hit", {31'h0, hit}, 0);
    chk("arst_inst", {16'h0, inst}, 0);
    @(posedge clk);
    #1;
    trim_aq();
    hold  = 1'b0;
    rst_n = 1'b1;
    fetch(16'h0012, 1'b1);
    fetch(16'h0013, 1'b0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
